// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size codes and FSM state encodings for the memory stage
package mem_stage_pkg;

    // Access size codes carried by ctrl_mem_read / ctrl_mem_write
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_W    = 2'd1;
    localparam logic [1:0] MEM_H    = 2'd2;
    localparam logic [1:0] MEM_B    = 2'd3;

    // Access sequencer states
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // True when the size/offset pair cannot be served by one aligned bus access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if (size == MEM_W) r = (addr_lo != 2'b00);
        else if (size == MEM_H) r = addr_lo[0];
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and sign-extending extraction for loads
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Decode enables, replicate store data across lanes and extend the selected load lane
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = is_misaligned(i_size, i_addr_lo);
        case (i_size)
            MEM_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            MEM_H: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
            end
            MEM_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with variable-latency data-memory handshake
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic [31:0] EXMEM_pc_branch_i,
    input  logic [31:0] EXMEM_alu_i,
    input  logic        EXMEM_alu_do_branch_i,
    input  logic [31:0] EXMEM_b_i,
    input  logic [4:0]  EXMEM_reg_write_address_i,
    input  logic        EXMEM_ctrl_branch_i,
    input  logic [1:0]  EXMEM_ctrl_mem_read_i,
    input  logic [1:0]  EXMEM_ctrl_mem_write_i,
    input  logic        EXMEM_ctrl_reg_write_i,
    input  logic        EXMEM_ctrl_mem_to_reg_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        stall_o,
    output logic        pc_src_o,
    output logic [31:0] pc_branch_o,
    output logic [31:0] MEMWB_read_data_o,
    output logic [31:0] MEMWB_alu_o,
    output logic [4:0]  MEMWB_reg_write_address_o,
    output logic        MEMWB_ctrl_reg_write_o,
    output logic        MEMWB_ctrl_mem_to_reg_o,
    output logic        err_misaligned_o
);

    mem_state_e  r_state;
    mem_state_e  w_state_next;

    logic        w_is_read;
    logic        w_is_write;
    logic [1:0]  w_size;
    logic        w_misaligned;
    logic        w_access;
    logic        w_acked;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // A read wins when both read and write sizes are set
    assign w_is_read  = (EXMEM_ctrl_mem_read_i != MEM_NONE);
    assign w_is_write = !w_is_read && (EXMEM_ctrl_mem_write_i != MEM_NONE);
    assign w_size     = w_is_read ? EXMEM_ctrl_mem_read_i : EXMEM_ctrl_mem_write_i;

    mem_lane_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (EXMEM_alu_i[1:0]),
        .i_wdata      (EXMEM_b_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // Misaligned accesses never reach the bus; reset drops the request without a clock
    assign w_access     = (w_size != MEM_NONE) && !w_misaligned;
    assign dmem_req_o   = w_access && n_rst_i;
    assign dmem_we_o    = w_is_write;
    assign dmem_addr_o  = {EXMEM_alu_i[31:2], 2'b00};
    assign dmem_be_o    = w_be;
    assign dmem_wdata_o = w_wdata;

    // An ack with no request outstanding is ignored
    assign w_acked = dmem_req_o && dmem_ack_i;
    assign stall_o = dmem_req_o && !dmem_ack_i;

    assign pc_src_o    = EXMEM_ctrl_branch_i && EXMEM_alu_do_branch_i;
    assign pc_branch_o = EXMEM_pc_branch_i;

    // Sequencer state register
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) r_state <= MEM_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state: wait while the request is unacknowledged, return to idle on ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MEM_IDLE: if (dmem_req_o && !dmem_ack_i) w_state_next = MEM_WAIT;
            MEM_WAIT: if (w_acked)                   w_state_next = MEM_IDLE;
            default:                                 w_state_next = MEM_IDLE;
        endcase
    end

    // MEM/WB register: frozen while stalled so write-back forwarding stays valid
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            MEMWB_read_data_o         <= '0;
            MEMWB_alu_o               <= '0;
            MEMWB_reg_write_address_o <= '0;
            MEMWB_ctrl_reg_write_o    <= 1'b0;
            MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
        end else if (!stall_o) begin
            MEMWB_alu_o               <= EXMEM_alu_i;
            MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
            MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i && !w_misaligned;
            MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i;
            if (w_acked) MEMWB_read_data_o <= w_load_data;
        end
    end

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)          err_misaligned_o <= 1'b0;
        else if (w_misaligned) err_misaligned_o <= 1'b1;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        n_rst;
    logic [31:0] pc_branch_in;
    logic [31:0] alu_in;
    logic        do_branch;
    logic [31:0] b_in;
    logic [4:0]  rd_in;
    logic        ctrl_branch;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] rdata;
    logic        ack;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        err_mis;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk_i                     (clk),
        .n_rst_i                   (n_rst),
        .EXMEM_pc_branch_i         (pc_branch_in),
        .EXMEM_alu_i               (alu_in),
        .EXMEM_alu_do_branch_i     (do_branch),
        .EXMEM_b_i                 (b_in),
        .EXMEM_reg_write_address_i (rd_in),
        .EXMEM_ctrl_branch_i       (ctrl_branch),
        .EXMEM_ctrl_mem_read_i     (mem_read),
        .EXMEM_ctrl_mem_write_i    (mem_write),
        .EXMEM_ctrl_reg_write_i    (reg_write),
        .EXMEM_ctrl_mem_to_reg_i   (mem_to_reg),
        .dmem_req_o                (req),
        .dmem_we_o                 (we),
        .dmem_addr_o               (addr),
        .dmem_be_o                 (be),
        .dmem_wdata_o              (wdata),
        .dmem_rdata_i              (rdata),
        .dmem_ack_i                (ack),
        .stall_o                   (stall),
        .pc_src_o                  (pc_src),
        .pc_branch_o               (pc_branch),
        .MEMWB_read_data_o         (wb_read_data),
        .MEMWB_alu_o               (wb_alu),
        .MEMWB_reg_write_address_o (wb_rd),
        .MEMWB_ctrl_reg_write_o    (wb_reg_write),
        .MEMWB_ctrl_mem_to_reg_o   (wb_mem_to_reg),
        .err_misaligned_o          (err_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] pcb, input logic [31:0] alu, input logic [31:0] b,
                         input logic dob, input logic br, input logic [1:0] mr, input logic [1:0] mw,
                         input logic [4:0] rd, input logic rw, input logic m2r);
        pc_branch_in = pcb;
        alu_in       = alu;
        b_in         = b;
        do_branch    = dob;
        ctrl_branch  = br;
        mem_read     = mr;
        mem_write    = mw;
        rd_in        = rd;
        reg_write    = rw;
        mem_to_reg   = m2r;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        ack   = 1'b0;
        rdata = 32'h0;
        drive(32'h0, 32'h10, 32'h0, 1'b0, 1'b0, 2'd1, 2'd0, 5'd3, 1'b1, 1'b1);
        #12;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if ({wb_read_data, wb_alu, wb_rd, wb_reg_write, wb_mem_to_reg} !== 71'h0) begin
            errors++; $display("FAIL reset_memwb: got %h/%h/%h/%b/%b expected all 0", wb_read_data, wb_alu, wb_rd, wb_reg_write, wb_mem_to_reg); end
        checks++; if (err_mis !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_mis); end
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word;
        drive(32'h0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0);
        ack = 1'b1;
        #3;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b expected 1", req); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", we); end
        checks++; if (addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", addr); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", be); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        ack = 1'b0;
        checks++; if (wb_alu !== 32'h100) begin errors++; $display("FAIL sw_wb_alu: got %h expected 00000100", wb_alu); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL sw_wb_rw: got %b expected 0", wb_reg_write); end
    endtask

    task automatic test_half;
        drive(32'h0, 32'h102, 32'h00001234, 1'b0, 1'b0, 2'd0, 2'd2, 5'd0, 1'b0, 1'b0);
        ack = 1'b1;
        #3;
        checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", be); end
        checks++; if (wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h expected 12341234", wdata); end
        @(posedge clk); #1;
        drive(32'h0, 32'h102, 32'h0, 1'b0, 1'b0, 2'd2, 2'd0, 5'd5, 1'b1, 1'b1);
        rdata = 32'h7FFF0000;
        #3;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL lh_we: got %b expected 0", we); end
        @(posedge clk); #1;
        ack = 1'b0;
        checks++; if (wb_read_data !== 32'h00007FFF) begin errors++; $display("FAIL lh_data: got %h expected 00007fff", wb_read_data); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL lh_rd: got %0d expected 5", wb_rd); end
        checks++; if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1) begin
            errors++; $display("FAIL lh_ctrl: got rw=%b m2r=%b expected 1/1", wb_reg_write, wb_mem_to_reg); end
    endtask

    task automatic test_load_byte_wait;
        drive(32'h0, 32'h103, 32'h0, 1'b0, 1'b0, 2'd3, 2'd0, 5'd7, 1'b1, 1'b1);
        rdata = 32'h80FF0011;
        ack   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_%0d: got %b expected 1", k, stall); end
            checks++; if (wb_alu !== 32'h102) begin errors++; $display("FAIL lb_hold_%0d: got %h expected 00000102", k, wb_alu); end
            @(posedge clk); #1;
        end
        ack = 1'b1;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_ack_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        ack = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (wb_read_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", wb_read_data); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL lb_rw: got %b expected 1", wb_reg_write); end
        checks++; if (wb_alu !== 32'h103 || wb_rd !== 5'd7) begin
            errors++; $display("FAIL lb_fields: got alu=%h rd=%0d expected 00000103/7", wb_alu, wb_rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned;
        drive(32'h0, 32'h101, 32'h0, 1'b0, 1'b0, 2'd1, 2'd0, 5'd4, 1'b1, 1'b1);
        rdata = 32'h12345678;
        ack   = 1'b0;
        #3;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        checks++; if (err_mis !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", err_mis); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_rw: got %b expected 0", wb_reg_write); end
        checks++; if (wb_read_data !== 32'hFFFFFF80) begin errors++; $display("FAIL mis_data_hold: got %h expected ffffff80", wb_read_data); end
        drive(32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++; if (err_mis !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", err_mis); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_rw: got %b expected 1", wb_reg_write); end
    endtask

    task automatic test_branch;
        drive(32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL br_taken: got %b expected 1", pc_src); end
        checks++; if (pc_branch !== 32'h40) begin errors++; $display("FAIL br_target: got %h expected 00000040", pc_branch); end
        do_branch = 1'b0;
        #1;
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br_not_taken: got %b expected 0", pc_src); end
        drive(32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait;
        drive(32'h0, 32'h200, 32'h0, 1'b0, 1'b0, 2'd1, 2'd0, 5'd9, 1'b1, 1'b1);
        ack = 1'b0;
        #3;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rw_drop: got req=%b stall=%b expected 0/0", req, stall); end
        checks++; if ({wb_read_data, wb_alu, wb_rd, wb_reg_write, wb_mem_to_reg} !== 71'h0) begin
            errors++; $display("FAIL rw_memwb: got %h/%h/%h/%b/%b expected all 0", wb_read_data, wb_alu, wb_rd, wb_reg_write, wb_mem_to_reg); end
        checks++; if (err_mis !== 1'b0) begin errors++; $display("FAIL rw_err: got %b expected 0", err_mis); end
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        ack   = 1'b1;
        rdata = 32'hAAAAAAAA;
        @(posedge clk); #1;
        checks++; if (wb_read_data !== 32'h0) begin errors++; $display("FAIL rw_stray_ack: got %h expected 00000000", wb_read_data); end
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rw_idle: got req=%b stall=%b expected 0/0", req, stall); end
        ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_half;
        test_load_byte_wait;
        test_misaligned;
        test_branch;
        test_reset_in_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
